// File: rtl/cmp682_sched_pkg.sv
// Shared types and helpers for the comparator time-sharing scheduler.
package cmp682_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Comparator outputs are active-low; when both assert, equality wins.
  function automatic logic [2:0] map_result(input logic eq_n, input logic gt_n);
    logic eq;
    logic gt;
    eq = ~eq_n;
    gt = ~gt_n & eq_n;
    return {eq, gt, ~eq & ~gt};
  endfunction

endpackage

// File: rtl/cmp682_sched_rr_arb.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1 with wrap.
module cmp682_sched_rr_arb
  import cmp682_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [clog2(NREQ)-1:0]  ptr_i,
  output logic                    valid_o,
  output logic [clog2(NREQ)-1:0]  win_o
);

  localparam int IDW = clog2(NREQ);

  int idx;

  // Walk from farthest to nearest so the nearest candidate after ptr is the last write.
  always_comb begin
    valid_o = 1'b0;
    win_o   = '0;
    idx     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr_i) + i) % NREQ;
      if (req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/cmp682_sched.sv
// Round-robin scheduler sharing one external 8-bit TTL magnitude comparator among NREQ requesters.
module cmp682_sched
  import cmp682_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       p_in,
  input  logic                    q_ld,
  input  logic [7:0]              q_in,
  output logic [7:0]              cmp_p,
  output logic [7:0]              cmp_q,
  input  logic                    cmp_eq_n,
  input  logic                    cmp_gt_n,
  output logic [NREQ-1:0]         ack,
  output logic [clog2(NREQ)-1:0]  gnt_id,
  output logic                    res_eq,
  output logic                    res_gt,
  output logic                    res_lt,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int IDW = clog2(NREQ);
  // A settle time of zero still holds operands for one cycle.
  localparam logic [15:0] CNT_INIT = (SETTLE <= 1) ? 16'd0 : 16'(SETTLE - 1);

  // Handshake: req[i] is a level held until ack[i]; ack[i] is a single-cycle
  // pulse carrying valid res_*; req is only sampled while IDLE.

  state_e            state_q;
  logic [15:0]       cnt_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    gnt_q;
  logic [7:0]        q_reg_q;
  logic [7:0]        p_q;
  logic [NREQ-1:0]   ack_q;
  logic [2:0]        res_q;
  logic              busy_q;

  logic              arb_valid;
  logic [IDW-1:0]    arb_win;
  logic [7:0]        p_sel_d;
  logic [NREQ-1:0]   ack_d;
  logic [2:0]        res_d;

  cmp682_sched_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .win_o   (arb_win)
  );

  always_comb begin
    p_sel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_win == IDW'(i)) p_sel_d = p_in[8*i +: 8];
    end
    ack_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == IDW'(i)) ack_d[i] = 1'b1;
    end
    res_d = map_result(cmp_eq_n, cmp_gt_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      gnt_q   <= '0;
      q_reg_q <= '0;
      p_q     <= '0;
      ack_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (q_ld) q_reg_q <= q_in;
          if (arb_valid) begin
            p_q     <= p_sel_d;
            gnt_q   <= arb_win;
            ptr_q   <= arb_win;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            res_q   <= res_d;
            ack_q   <= ack_d;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmp_p     = p_q;
  assign cmp_q     = q_reg_q;
  assign ack       = ack_q;
  assign gnt_id    = gnt_q;
  assign res_eq    = res_q[2];
  assign res_gt    = res_q[1];
  assign res_lt    = res_q[0];
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
